// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Shares one single-port synchronous framebuffer RAM between the VGA scan-out
// path and a host write port. Display reads always take priority. Host writes
// queue in a 2-entry FIFO and go to the RAM in cycles with no display read.
// Each framebuffer word covers a 4x4 block of screen pixels.
//
// Ports
//   CLK, RST_n             clock, asynchronous active-low reset
//   VSYNC_Sig              vertical sync (active-low pulse); falling edge = frame start
//   Ready_Sig              timing generator active-area flag
//   Column_Addr_Sig        active x (0..639)
//   Row_Addr_Sig           active y (0..479)
//   Disp_En                display enable request
//   Wr_Valid/Wr_Ready      host write handshake
//   Wr_Addr/Wr_Data        host write word
//   Wr_Err                 one-cycle pulse when an out-of-range host write is dropped
//   Ram_Addr/We/Wdata      registered RAM command
//   Ram_Rdata              RAM read data, valid one cycle after the command
//   Rgb_Out/Rgb_Valid      pixel stream to the DAC
//   Frame_Start            one-cycle pulse at each displayed frame start
module vga_fb_arbiter #(
  parameter int FB_W   = 160,
  parameter int FB_H   = 120,
  parameter int ADDR_W = 15,
  parameter int DW     = 8
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              VSYNC_Sig,
  input  logic              Ready_Sig,
  input  logic [10:0]       Column_Addr_Sig,
  input  logic [10:0]       Row_Addr_Sig,
  input  logic              Disp_En,
  input  logic              Wr_Valid,
  output logic              Wr_Ready,
  input  logic [ADDR_W-1:0] Wr_Addr,
  input  logic [DW-1:0]     Wr_Data,
  output logic              Wr_Err,
  output logic [ADDR_W-1:0] Ram_Addr,
  output logic              Ram_We,
  output logic [DW-1:0]     Ram_Wdata,
  input  logic [DW-1:0]     Ram_Rdata,
  output logic [DW-1:0]     Rgb_Out,
  output logic              Rgb_Valid,
  output logic              Frame_Start
);

  localparam int          STAGES = 3;
  localparam logic [15:0] FB_W_V = 16'(FB_W);
  localparam logic [ADDR_W:0] FB_LIM = (ADDR_W+1)'(FB_W * FB_H);

  typedef enum logic [1:0] {OFF, WAIT_VS, ACTIVE} state_t;

  state_t state_q, state_d;
  logic   fs_d, fs_q;
  logic   vs_d;
  logic   vs_fall;

  // ---------------------------------------------------------------- frame FSM
  assign vs_fall = vs_d & ~VSYNC_Sig;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= OFF;
      fs_q    <= 1'b0;
      vs_d    <= 1'b0;
    end else begin
      state_q <= state_d;
      fs_q    <= fs_d;
      vs_d    <= VSYNC_Sig;
    end
  end

  always_comb begin
    state_d = state_q;
    fs_d    = 1'b0;
    case (state_q)
      OFF:     if (Disp_En) state_d = WAIT_VS;
      WAIT_VS: begin
        if (!Disp_En) state_d = OFF;
        else if (vs_fall) begin
          state_d = ACTIVE;
          fs_d    = 1'b1;
        end
      end
      ACTIVE: begin
        // Disp_En is only sampled at frame boundaries so a frame always completes.
        if (vs_fall) begin
          if (Disp_En) fs_d = 1'b1;
          else state_d = OFF;
        end
      end
      default: state_d = OFF;
    endcase
  end

  assign Frame_Start = fs_q;

  // ------------------------------------------------------- display read strobe
  logic              act_rdy;
  logic              strobe;
  logic [31:0]       disp_sum;
  logic [ADDR_W-1:0] disp_addr;

  assign act_rdy = (state_q == ACTIVE) && Ready_Sig;
  assign strobe  = act_rdy && (Column_Addr_Sig[1:0] == 2'b00) &&
                   (Column_Addr_Sig < 11'd640) && (Row_Addr_Sig < 11'd480);

  // (row>>2)*FB_W expanded into shifted adds of the set bits of FB_W.
  function automatic logic [31:0] row_base(input logic [8:0] r);
    logic [31:0] acc;
    acc = '0;
    for (int b = 0; b < 16; b++)
      if (FB_W_V[b]) acc = acc + ({23'd0, r} << b);
    return acc;
  endfunction

  assign disp_sum  = row_base(Row_Addr_Sig[10:2]) + {23'd0, Column_Addr_Sig[10:2]};
  assign disp_addr = ADDR_W'(disp_sum);

  // -------------------------------------------------------- host write FIFO
  logic [ADDR_W-1:0] f_addr [2];
  logic [DW-1:0]     f_data [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic              en_q;
  logic              push, pop;
  logic [ADDR_W-1:0] pop_addr;
  logic [DW-1:0]     pop_data;
  logic              pop_ok;

  // en_q keeps Wr_Ready low while in reset and raises it one edge after release.
  assign Wr_Ready = en_q && (count != 2'd2);
  assign push     = Wr_Valid && Wr_Ready;
  // Only entries already stored may pop, so a push into an empty FIFO pops next cycle.
  assign pop      = (count != 2'd0) && !strobe;
  assign pop_addr = f_addr[rd_ptr];
  assign pop_data = f_data[rd_ptr];
  assign pop_ok   = ({1'b0, pop_addr} < FB_LIM);

  always_ff @(posedge CLK) begin
    if (push) begin
      f_addr[wr_ptr] <= Wr_Addr;
      f_data[wr_ptr] <= Wr_Data;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      en_q   <= 1'b0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      en_q <= 1'b1;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // ------------------------------------------------------- RAM command register
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      Ram_Addr  <= '0;
      Ram_We    <= 1'b0;
      Ram_Wdata <= '0;
      Wr_Err    <= 1'b0;
    end else begin
      Ram_We <= 1'b0;
      Wr_Err <= 1'b0;
      if (strobe) begin
        Ram_Addr <= disp_addr;
      end else if (pop) begin
        if (pop_ok) begin
          Ram_Addr  <= pop_addr;
          Ram_Wdata <= pop_data;
          Ram_We    <= 1'b1;
        end else begin
          Wr_Err <= 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------------ pixel pipeline
  // strobe -> command (t+1) -> read data (t+2) -> pixel register (t+3).
  logic [STAGES:1] vld_pipe;
  logic [2:1]      strb_pipe;
  logic [DW-1:0]   pix_q;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      vld_pipe  <= '0;
      strb_pipe <= '0;
      pix_q     <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], act_rdy};
      strb_pipe <= {strb_pipe[1], strobe};
      // Held across the three non-strobe columns of each 4-pixel word.
      if (strb_pipe[2]) pix_q <= Ram_Rdata;
    end
  end

  assign Rgb_Valid = vld_pipe[STAGES];
  assign Rgb_Out   = Rgb_Valid ? pix_q : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;
  localparam int ADDR_W = 15;
  localparam int DW     = 8;

  logic              CLK = 1'b0;
  logic              RST_n;
  logic              VSYNC_Sig, Ready_Sig, Disp_En, Wr_Valid;
  logic [10:0]       Column_Addr_Sig, Row_Addr_Sig;
  logic [ADDR_W-1:0] Wr_Addr, Ram_Addr;
  logic [DW-1:0]     Wr_Data, Ram_Wdata, Ram_Rdata, Rgb_Out;
  logic              Wr_Ready, Wr_Err, Ram_We, Rgb_Valid, Frame_Start;

  int checks = 0;
  int errors = 0;
  int fs_cnt = 0;
  logic [DW-1:0]        mem [32768];
  logic [ADDR_W+DW-1:0] wq [$];

  vga_fb_arbiter #(.FB_W(160), .FB_H(120), .ADDR_W(ADDR_W), .DW(DW)) dut (
    .CLK(CLK), .RST_n(RST_n), .VSYNC_Sig(VSYNC_Sig), .Ready_Sig(Ready_Sig),
    .Column_Addr_Sig(Column_Addr_Sig), .Row_Addr_Sig(Row_Addr_Sig), .Disp_En(Disp_En),
    .Wr_Valid(Wr_Valid), .Wr_Ready(Wr_Ready), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
    .Wr_Err(Wr_Err), .Ram_Addr(Ram_Addr), .Ram_We(Ram_We), .Ram_Wdata(Ram_Wdata),
    .Ram_Rdata(Ram_Rdata), .Rgb_Out(Rgb_Out), .Rgb_Valid(Rgb_Valid), .Frame_Start(Frame_Start)
  );

  always #5 CLK = ~CLK;

  // Synchronous single-port RAM, read-before-write.
  always @(posedge CLK) begin
    Ram_Rdata <= mem[Ram_Addr];
    if (Ram_We) mem[Ram_Addr] <= Ram_Wdata;
  end

  always @(negedge CLK) begin
    if (Ram_We) wq.push_back({Ram_Addr, Ram_Wdata});
    if (Frame_Start) fs_cnt++;
  end

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    checks++; if (Ram_We !== 1'b0) begin errors++; $display("FAIL rst_we: got %0h want 0", Ram_We); end
    checks++; if (Ram_Addr !== '0) begin errors++; $display("FAIL rst_addr: got %0h want 0", Ram_Addr); end
    checks++; if (Ram_Wdata !== '0) begin errors++; $display("FAIL rst_wdata: got %0h want 0", Ram_Wdata); end
    checks++; if (Rgb_Out !== '0) begin errors++; $display("FAIL rst_rgb: got %0h want 0", Rgb_Out); end
    checks++; if (Rgb_Valid !== 1'b0) begin errors++; $display("FAIL rst_rgbv: got %0h want 0", Rgb_Valid); end
    checks++; if (Frame_Start !== 1'b0) begin errors++; $display("FAIL rst_fs: got %0h want 0", Frame_Start); end
    checks++; if (Wr_Err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0h want 0", Wr_Err); end
    checks++; if (Wr_Ready !== 1'b0) begin errors++; $display("FAIL rst_rdy: got %0h want 0", Wr_Ready); end
    RST_n = 1'b1;
    @(negedge CLK);
    checks++; if (Wr_Ready !== 1'b1) begin errors++; $display("FAIL rel_rdy: got %0h want 1", Wr_Ready); end
  endtask

  task automatic test_host_write();
    @(negedge CLK); Wr_Valid = 1'b1; Wr_Addr = 15'd100; Wr_Data = 8'h3C;
    @(negedge CLK); Wr_Valid = 1'b0;
    checks++; if (Ram_We !== 1'b0) begin errors++; $display("FAIL hw_early: got %0h want 0", Ram_We); end
    @(negedge CLK);
    checks++; if (Ram_We !== 1'b1) begin errors++; $display("FAIL hw_we: got %0h want 1", Ram_We); end
    checks++; if (Ram_Addr !== 15'd100) begin errors++; $display("FAIL hw_addr: got %0d want 100", Ram_Addr); end
    checks++; if (Ram_Wdata !== 8'h3C) begin errors++; $display("FAIL hw_data: got %0h want 3c", Ram_Wdata); end
    @(negedge CLK);
    checks++; if (Ram_We !== 1'b0) begin errors++; $display("FAIL hw_idle_we: got %0h want 0", Ram_We); end
    checks++; if (Ram_Addr !== 15'd100) begin errors++; $display("FAIL hw_hold: got %0d want 100", Ram_Addr); end
  endtask

  task automatic test_wr_err();
    @(negedge CLK); Wr_Valid = 1'b1; Wr_Addr = 15'd19200; Wr_Data = 8'hFF;
    @(negedge CLK); Wr_Addr = 15'd200; Wr_Data = 8'h11;
    @(negedge CLK); Wr_Valid = 1'b0;
    checks++; if (Wr_Err !== 1'b1) begin errors++; $display("FAIL err_pulse: got %0h want 1", Wr_Err); end
    checks++; if (Ram_We !== 1'b0) begin errors++; $display("FAIL err_we: got %0h want 0", Ram_We); end
    checks++; if (Ram_Addr !== 15'd100) begin errors++; $display("FAIL err_addr: got %0d want 100", Ram_Addr); end
    @(negedge CLK);
    checks++; if (Wr_Err !== 1'b0) begin errors++; $display("FAIL err_clr: got %0h want 0", Wr_Err); end
    checks++; if (Ram_We !== 1'b1) begin errors++; $display("FAIL err_next_we: got %0h want 1", Ram_We); end
    checks++; if (Ram_Addr !== 15'd200) begin errors++; $display("FAIL err_next_addr: got %0d want 200", Ram_Addr); end
    checks++; if (Ram_Wdata !== 8'h11) begin errors++; $display("FAIL err_next_data: got %0h want 11", Ram_Wdata); end
  endtask

  task automatic test_back_to_back();
    @(negedge CLK); wq.delete();
    for (int i = 0; i < 4; i++) begin
      checks++; if (Wr_Ready !== 1'b1) begin errors++; $display("FAIL b2b_rdy%0d: got %0h want 1", i, Wr_Ready); end
      Wr_Valid = 1'b1; Wr_Addr = 15'(50 + i); Wr_Data = 8'(8'h20 + i);
      @(negedge CLK);
    end
    Wr_Valid = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (wq.size() != 4) begin errors++; $display("FAIL b2b_cnt: got %0d want 4", wq.size()); end
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== {15'(50 + i), 8'(8'h20 + i)}) begin
        errors++; $display("FAIL b2b_ord%0d: got %0h want %0h", i, wq[i], {15'(50 + i), 8'(8'h20 + i)});
      end
    end
  endtask

  task automatic test_frame_start();
    @(negedge CLK); fs_cnt = 0;
    Disp_En = 1'b1; VSYNC_Sig = 1'b1; Ready_Sig = 1'b1; Row_Addr_Sig = 11'd8; Column_Addr_Sig = 11'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK); Column_Addr_Sig = Column_Addr_Sig + 11'd1;
      checks++; if (Rgb_Valid !== 1'b0) begin errors++; $display("FAIL fs_novld%0d: got %0h want 0", i, Rgb_Valid); end
    end
    @(negedge CLK); VSYNC_Sig = 1'b0; Ready_Sig = 1'b0;
    @(negedge CLK); VSYNC_Sig = 1'b1;
    checks++; if (Frame_Start !== 1'b1) begin errors++; $display("FAIL fs_pulse: got %0h want 1", Frame_Start); end
    @(negedge CLK);
    checks++; if (Frame_Start !== 1'b0) begin errors++; $display("FAIL fs_end: got %0h want 0", Frame_Start); end
    repeat (3) @(negedge CLK);
    checks++; if (fs_cnt != 1) begin errors++; $display("FAIL fs_count: got %0d want 1", fs_cnt); end
  endtask

  task automatic test_pixel();
    mem[161] = 8'hA5; mem[162] = 8'h77;
    @(negedge CLK); Row_Addr_Sig = 11'd4; Column_Addr_Sig = 11'd4; Ready_Sig = 1'b1;
    @(negedge CLK); Column_Addr_Sig = 11'd5;
    checks++; if (Ram_Addr !== 15'd161) begin errors++; $display("FAIL px_addr: got %0d want 161", Ram_Addr); end
    checks++; if (Ram_We !== 1'b0) begin errors++; $display("FAIL px_we: got %0h want 0", Ram_We); end
    @(negedge CLK); Column_Addr_Sig = 11'd6;
    checks++; if (Rgb_Valid !== 1'b0) begin errors++; $display("FAIL px_early: got %0h want 0", Rgb_Valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (i == 0) Column_Addr_Sig = 11'd7;
      if (i == 1) Column_Addr_Sig = 11'd8;
      if (i == 2) begin
        Ready_Sig = 1'b0;
        checks++; if (Ram_Addr !== 15'd162) begin errors++; $display("FAIL px_addr2: got %0d want 162", Ram_Addr); end
      end
      checks++; if (Rgb_Valid !== 1'b1) begin errors++; $display("FAIL px_vld%0d: got %0h want 1", i, Rgb_Valid); end
      checks++; if (Rgb_Out !== 8'hA5) begin errors++; $display("FAIL px_rgb%0d: got %0h want a5", i, Rgb_Out); end
    end
    @(negedge CLK);
    checks++; if (Rgb_Out !== 8'h77 || Rgb_Valid !== 1'b1) begin errors++; $display("FAIL px_next: got %0h/%0h want 77/1", Rgb_Out, Rgb_Valid); end
    @(negedge CLK);
    checks++; if (Rgb_Valid !== 1'b0 || Rgb_Out !== 8'h00) begin errors++; $display("FAIL px_off: got %0h/%0h want 0/0", Rgb_Out, Rgb_Valid); end
  endtask

  task automatic test_contention();
    int n = 0, low = 0;
    logic acc = 1'b0;
    wq.delete(); Row_Addr_Sig = 11'd8;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      if (i > 0 && acc) n++;
      if (i > 0 && ((i - 1) % 4 == 0)) begin
        checks++;
        if (Ram_We !== 1'b0 || Ram_Addr !== 15'(320 + (i - 1) / 4)) begin
          errors++; $display("FAIL ct_read%0d: got we=%0h addr=%0d want we=0 addr=%0d", i, Ram_We, Ram_Addr, 320 + (i - 1) / 4);
        end
      end
      Column_Addr_Sig = 11'(i); Ready_Sig = 1'b1;
      Wr_Valid = 1'b1; Wr_Addr = 15'(1000 + n); Wr_Data = 8'(n);
      acc = Wr_Ready;
      if (!Wr_Ready) low++;
    end
    @(negedge CLK);
    if (acc) n++;
    Ready_Sig = 1'b0; Wr_Valid = 1'b0;
    repeat (4) @(negedge CLK);
    checks++; if (n != 13) begin errors++; $display("FAIL ct_pushes: got %0d want 13", n); end
    checks++; if (low != 3) begin errors++; $display("FAIL ct_rdylow: got %0d want 3", low); end
    checks++; if (wq.size() != n) begin errors++; $display("FAIL ct_writes: got %0d want %0d", wq.size(), n); end
    for (int k = 0; k < n && k < wq.size(); k++) begin
      checks++;
      if (wq[k] !== {15'(1000 + k), 8'(k)}) begin
        errors++; $display("FAIL ct_ord%0d: got %0h want %0h", k, wq[k], {15'(1000 + k), 8'(k)});
      end
    end
  endtask

  task automatic test_disp_off();
    @(negedge CLK); fs_cnt = 0; Disp_En = 1'b0; Ready_Sig = 1'b1; Row_Addr_Sig = 11'd0; Column_Addr_Sig = 11'd0;
    @(negedge CLK); Ready_Sig = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    checks++; if (Rgb_Valid !== 1'b1) begin errors++; $display("FAIL off_finish: got %0h want 1", Rgb_Valid); end
    @(negedge CLK); VSYNC_Sig = 1'b0;
    @(negedge CLK); VSYNC_Sig = 1'b1;
    checks++; if (Frame_Start !== 1'b0) begin errors++; $display("FAIL off_nofs: got %0h want 0", Frame_Start); end
    @(negedge CLK); Ready_Sig = 1'b1;
    @(negedge CLK); Ready_Sig = 1'b0;
    checks++; if (Ram_We !== 1'b0) begin errors++; $display("FAIL off_we: got %0h want 0", Ram_We); end
    repeat (2) @(negedge CLK);
    checks++; if (Rgb_Valid !== 1'b0) begin errors++; $display("FAIL off_novld: got %0h want 0", Rgb_Valid); end
    checks++; if (fs_cnt != 0) begin errors++; $display("FAIL off_fscnt: got %0d want 0", fs_cnt); end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK); Disp_En = 1'b1;
    @(negedge CLK); VSYNC_Sig = 1'b0;
    @(negedge CLK); VSYNC_Sig = 1'b1;
    @(negedge CLK); Ready_Sig = 1'b1; Row_Addr_Sig = 11'd0; Column_Addr_Sig = 11'd0;
    Wr_Valid = 1'b1; Wr_Addr = 15'd3000; Wr_Data = 8'h99;
    @(negedge CLK); Wr_Addr = 15'd3001; Wr_Data = 8'h9A;
    @(negedge CLK); Wr_Valid = 1'b0;
    checks++; if (Wr_Ready !== 1'b0) begin errors++; $display("FAIL rm_full: got %0h want 0", Wr_Ready); end
    @(negedge CLK);
    checks++; if (Rgb_Valid !== 1'b1) begin errors++; $display("FAIL rm_vld: got %0h want 1", Rgb_Valid); end
    wq.delete();
    #1 RST_n = 1'b0;
    #1;
    checks++; if (Rgb_Valid !== 1'b0 || Rgb_Out !== '0) begin errors++; $display("FAIL rm_rgb: got %0h/%0h want 0/0", Rgb_Out, Rgb_Valid); end
    checks++; if (Wr_Ready !== 1'b0) begin errors++; $display("FAIL rm_rdy: got %0h want 0", Wr_Ready); end
    checks++; if (Ram_We !== 1'b0 || Ram_Addr !== '0 || Ram_Wdata !== '0) begin errors++; $display("FAIL rm_ram: got %0h/%0h/%0h want 0/0/0", Ram_We, Ram_Addr, Ram_Wdata); end
    checks++; if (Frame_Start !== 1'b0 || Wr_Err !== 1'b0) begin errors++; $display("FAIL rm_pulse: got %0h/%0h want 0/0", Frame_Start, Wr_Err); end
    @(negedge CLK); Ready_Sig = 1'b0; RST_n = 1'b1;
    repeat (4) @(negedge CLK);
    checks++; if (Wr_Ready !== 1'b1) begin errors++; $display("FAIL rm_rel_rdy: got %0h want 1", Wr_Ready); end
    checks++; if (wq.size() != 0) begin errors++; $display("FAIL rm_stale: got %0d writes want 0", wq.size()); end
    checks++; if (Rgb_Valid !== 1'b0) begin errors++; $display("FAIL rm_rel_vld: got %0h want 0", Rgb_Valid); end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = '0;
    RST_n = 1'b0; VSYNC_Sig = 1'b1; Ready_Sig = 1'b0; Disp_En = 1'b0; Wr_Valid = 1'b0;
    Column_Addr_Sig = '0; Row_Addr_Sig = '0; Wr_Addr = '0; Wr_Data = '0;
    test_reset();
    test_host_write();
    test_wr_err();
    test_back_to_back();
    test_frame_start();
    test_pixel();
    test_contention();
    test_disp_off();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
